// File: rtl/load_store_unit.sv
// RV32I load/store unit: word-addressed memory initiator with sub-word RMW.
// Optional LSU_STATS_EN adds load/store/fault completion counters.
module load_store_unit #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_error,
    output logic [XLEN-1:0] mem_address,
    output logic [XLEN-1:0] mem_write_data,
    output logic            mem_write_enable,
`ifdef LSU_STATS_EN
    output logic [31:0]     stat_loads,
    output logic [31:0]     stat_stores,
    output logic [31:0]     stat_faults,
`endif
    input  logic [XLEN-1:0] mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MERGE,
        S_WRITE,
        S_RESP
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] data_q;
    logic [2:0]      funct3_q;
    logic            write_q;

    logic            accept;
    logic            fault;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] merged;

    assign accept = req_valid && req_ready;

    // Misalignment or unsupported funct3 for the incoming request
    always_comb begin
        fault = 1'b0;
        if (req_funct3[1:0] == 2'd1 && req_addr[0])
            fault = 1'b1;
        if (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0)
            fault = 1'b1;
        if (req_write && req_funct3 >= 3'd3)
            fault = 1'b1;
        if (!req_write && (req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11))
            fault = 1'b1;
    end

    // Pick the addressed lane out of the read word and extend it
    always_comb begin
        shifted  = mem_read_data >> {addr_q[1:0], 3'b000};
        load_val = shifted;
        case (funct3_q)
            3'd0: load_val = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'd1: load_val = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'd4: load_val = {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'd5: load_val = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    // Overlay store bytes onto the current memory word for SB/SH
    always_comb begin
        merged = mem_read_data;
        if (funct3_q[1:0] == 2'd0)
            merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
    end

    // Next state and memory/handshake outputs
    always_comb begin
        state_d          = state_q;
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        mem_address      = '0;
        mem_write_data   = '0;
        mem_write_enable = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    if (fault)
                        state_d = S_RESP;
                    else if (!req_write)
                        state_d = S_LOAD;
                    else if (req_funct3[1:0] == 2'd2)
                        state_d = S_WRITE;
                    else
                        state_d = S_MERGE;
                end
            end
            S_LOAD: begin
                mem_address = {2'b00, addr_q[XLEN-1:2]};
                state_d     = S_RESP;
            end
            S_MERGE: begin
                mem_address = {2'b00, addr_q[XLEN-1:2]};
                state_d     = S_WRITE;
            end
            S_WRITE: begin
                mem_address      = {2'b00, addr_q[XLEN-1:2]};
                mem_write_data   = data_q;
                mem_write_enable = 1'b1;
                state_d          = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register, request latch and response registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            funct3_q   <= '0;
            write_q    <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        addr_q   <= req_addr;
                        data_q   <= req_wdata;
                        funct3_q <= req_funct3;
                        write_q  <= req_write;
                        if (fault) begin
                            resp_rdata <= '0;
                            resp_error <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    resp_rdata <= load_val;
                    resp_error <= 1'b0;
                end
                S_MERGE: data_q <= merged;
                S_WRITE: begin
                    resp_rdata <= '0;
                    resp_error <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef LSU_STATS_EN
    // Count each completion once, faults taking priority over kind
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_loads  <= '0;
            stat_stores <= '0;
            stat_faults <= '0;
        end else if (state_q == S_RESP) begin
            if (resp_error)
                stat_faults <= stat_faults + 32'd1;
            else if (write_q)
                stat_stores <= stat_stores + 32'd1;
            else
                stat_loads <= stat_loads + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a byte-level memory model.
// Define LSU_STATS_EN to also exercise the statistics counters.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;
`ifdef LSU_STATS_EN
    logic [31:0] stat_loads;
    logic [31:0] stat_stores;
    logic [31:0] stat_faults;
`endif

    load_store_unit #(.XLEN(32)) dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_error       (resp_error),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
`ifdef LSU_STATS_EN
        .stat_loads       (stat_loads),
        .stat_stores      (stat_stores),
        .stat_faults      (stat_faults),
`endif
        .mem_read_data    (mem_read_data)
    );

    always #5 clock = ~clock;

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;

    assign mem_read_data = mem[mem_address[5:0]];

    always @(posedge clock) begin
        if (mem_write_enable)
            mem[mem_address[5:0]] <= mem_write_data;
        else if (pl_en)
            mem[pl_idx] <= pl_val;
    end

    int checks = 0;
    int failures = 0;

    logic        obs_ready;
    int          obs_lat;
    logic [31:0] obs_rdata;
    logic        obs_err;
    int          obs_nwr;
    logic [31:0] obs_waddr;
    logic [31:0] obs_wdata;
    logic [31:0] obs_raddr;

    task automatic set_word(input int idx, input logic [31:0] val);
        @(negedge clock);
        pl_en  = 1'b1;
        pl_idx = idx[5:0];
        pl_val = val;
        @(posedge clock);
        #1;
        pl_en = 1'b0;
        ref_mem[idx] = val;
    endtask

    // Expected outcome from byte-level RV32I semantics; updates ref_mem.
    function automatic void model(input bit w, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] d,
                                  output logic [31:0] e_rdata,
                                  output bit e_err, output int e_lat,
                                  output int e_nwr, output logic [31:0] e_wdata);
        int sz;
        bit bad;
        int idx;
        int off;
        logic [31:0] word;
        logic [31:0] v;
        logic [31:0] msk;
        sz  = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        bad = w ? (f3 >= 3) : (f3 == 3 || f3 == 6 || f3 == 7);
        if (a % sz != 0) bad = 1;
        idx  = (a / 4) % 64;
        off  = a % 4;
        word = ref_mem[idx];
        e_rdata = 0;
        e_wdata = 0;
        e_nwr   = 0;
        e_err   = 0;
        if (bad) begin
            e_err = 1;
            e_lat = 1;
        end else if (!w) begin
            v = word >> (8 * off);
            if (sz == 1) begin
                v = v % 256;
                if (f3 == 0 && v >= 128) v = v + 32'hFFFF_FF00;
            end else if (sz == 2) begin
                v = v % 65536;
                if (f3 == 1 && v >= 32768) v = v + 32'hFFFF_0000;
            end
            e_rdata = v;
            e_lat   = 2;
        end else begin
            for (int i = 0; i < sz; i++) begin
                msk  = 32'hFF << (8 * (off + i));
                word = (word & ~msk) | (((d >> (8 * i)) % 256) << (8 * (off + i)));
            end
            ref_mem[idx] = word;
            e_wdata = word;
            e_nwr   = 1;
            e_lat   = (sz == 4) ? 2 : 3;
        end
    endfunction

    // Issue one request and record what the DUT does until resp_valid.
    task automatic run_op(input bit w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          input bit hold);
        @(negedge clock);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        obs_ready  = req_ready;
        obs_lat    = 99;
        obs_nwr    = 0;
        obs_rdata  = 'x;
        obs_err    = 1'bx;
        obs_waddr  = 'x;
        obs_wdata  = 'x;
        obs_raddr  = 'x;
        @(posedge clock);
        #1;
        if (!hold) begin
            req_valid = 1'b0;
        end else begin
            req_write  = ~w;
            req_funct3 = 3'($urandom_range(0, 7));
            req_addr   = $urandom;
            req_wdata  = $urandom;
        end
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            if (mem_write_enable) begin
                obs_nwr++;
                obs_waddr = mem_address;
                obs_wdata = mem_write_data;
            end
            if (resp_valid) begin
                obs_lat   = i;
                obs_rdata = resp_rdata;
                obs_err   = resp_error;
                obs_raddr = mem_address;
                req_valid = 1'b0;
                break;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        reset      = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_write_enable !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got ready=%b valid=%b we=%b expected 1 0 0",
                     req_ready, resp_valid, mem_write_enable);
        end
        checks++;
        if (resp_rdata !== 32'h0 || resp_error !== 1'b0 || mem_address !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: got rdata=%h err=%b addr=%h expected 0 0 0",
                     resp_rdata, resp_error, mem_address);
        end
        for (int i = 0; i < 64; i++) set_word(i, $urandom);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_store_word;
        logic [31:0] er, ewd;
        bit ee;
        int el, ew;
        set_word(4, 32'h0);
        model(1, 3'd2, 32'h10, 32'hDEADBEEF, er, ee, el, ew, ewd);
        run_op(1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
        checks++;
        if (obs_nwr !== 1 || obs_waddr !== 32'd4 || obs_wdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL sw_write: got n=%0d addr=%h data=%h expected 1 4 deadbeef",
                     obs_nwr, obs_waddr, obs_wdata);
        end
        checks++;
        if (obs_err !== 1'b0 || obs_lat !== 2 || mem[4] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL sw_resp: got err=%b lat=%0d mem=%h expected 0 2 deadbeef",
                     obs_err, obs_lat, mem[4]);
        end
    endtask

    task automatic test_loads;
        logic [2:0]  f3s [4];
        logic [31:0] as  [4];
        logic [31:0] exp [4];
        f3s = '{3'd0, 3'd4, 3'd1, 3'd2};
        as  = '{32'h13, 32'h13, 32'h12, 32'h10};
        exp = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h80FF7F01};
        set_word(4, 32'h80FF7F01);
        for (int i = 0; i < 4; i++) begin
            run_op(0, f3s[i], as[i], $urandom, 0);
            checks++;
            if (obs_rdata !== exp[i] || obs_err !== 1'b0) begin
                failures++;
                $display("FAIL load_%0d: got rdata=%h err=%b expected %h 0",
                         i, obs_rdata, obs_err, exp[i]);
            end
            checks++;
            if (obs_lat !== 2 || obs_nwr !== 0 || obs_ready !== 1'b1) begin
                failures++;
                $display("FAIL load_%0d_timing: got lat=%0d writes=%0d ready=%b expected 2 0 1",
                         i, obs_lat, obs_nwr, obs_ready);
            end
        end
    endtask

    task automatic test_subword_store;
        logic [31:0] er, ewd;
        bit ee;
        int el, ew;
        set_word(4, 32'h11223344);
        model(1, 3'd0, 32'h11, 32'h000000AA, er, ee, el, ew, ewd);
        run_op(1, 3'd0, 32'h11, 32'h000000AA, 0);
        checks++;
        if (mem[4] !== 32'h1122AA44 || obs_lat !== 3 || obs_nwr !== 1) begin
            failures++;
            $display("FAIL sb: got mem=%h lat=%0d writes=%0d expected 1122aa44 3 1",
                     mem[4], obs_lat, obs_nwr);
        end
        model(1, 3'd1, 32'h12, 32'h1234BEEF, er, ee, el, ew, ewd);
        run_op(1, 3'd1, 32'h12, 32'h1234BEEF, 0);
        checks++;
        if (mem[4] !== 32'hBEEFAA44 || obs_lat !== 3 || obs_nwr !== 1) begin
            failures++;
            $display("FAIL sh: got mem=%h lat=%0d writes=%0d expected beefaa44 3 1",
                     mem[4], obs_lat, obs_nwr);
        end
    endtask

    task automatic test_faults;
        bit          ws  [5];
        logic [2:0]  f3s [5];
        logic [31:0] as  [5];
        ws  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        f3s = '{3'd2, 3'd1, 3'd3, 3'd3, 3'd7};
        as  = '{32'h12, 32'h11, 32'h10, 32'h10, 32'h10};
        for (int i = 0; i < 5; i++) begin
            run_op(0, 3'd2, 32'h10, 32'h0, 0);
            checks++;
            if (obs_rdata !== mem[4]) begin
                failures++;
                $display("FAIL pre_fault_lw_%0d: got %h expected %h", i, obs_rdata, mem[4]);
            end
            run_op(ws[i], f3s[i], as[i], 32'hFFFFFFFF, 0);
            checks++;
            if (obs_err !== 1'b1 || obs_rdata !== 32'h0) begin
                failures++;
                $display("FAIL fault_%0d: got err=%b rdata=%h expected 1 0",
                         i, obs_err, obs_rdata);
            end
            checks++;
            if (obs_lat !== 1 || obs_nwr !== 0 || mem[4] !== ref_mem[4]) begin
                failures++;
                $display("FAIL fault_%0d_timing: got lat=%0d writes=%0d mem=%h expected 1 0 %h",
                         i, obs_lat, obs_nwr, mem[4], ref_mem[4]);
            end
        end
    endtask

    task automatic test_reset_abort;
        int nwr;
        nwr = 0;
        set_word(5, 32'h55667788);
        @(negedge clock);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'd0;
        req_addr   = 32'h14;
        req_wdata  = 32'h99;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(negedge clock);
        if (mem_write_enable) nwr++;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: got ready=%b valid=%b expected 1 0",
                     req_ready, resp_valid);
        end
        for (int i = 0; i < 4; i++) begin
            if (mem_write_enable) nwr++;
            @(negedge clock);
        end
        checks++;
        if (nwr !== 0 || mem[5] !== 32'h55667788) begin
            failures++;
            $display("FAIL abort_nowrite: got writes=%0d mem=%h expected 0 55667788",
                     nwr, mem[5]);
        end
    endtask

    task automatic test_random(input int n, input bit hold);
        bit          w;
        logic [2:0]  f3;
        logic [31:0] a, d, er, ewd;
        bit          ee;
        int          el, ew;
        for (int k = 0; k < n; k++) begin
            w  = 1'($urandom_range(0, 1));
            f3 = w ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            a  = $urandom_range(0, 255);
            if ($urandom_range(0, 3) != 0)
                a = (f3[1:0] == 2'd2) ? (a & 32'hFC) :
                    (f3[1:0] == 2'd1) ? (a & 32'hFE) : a;
            d  = $urandom;
            model(w, f3, a, d, er, ee, el, ew, ewd);
            run_op(w, f3, a, d, hold);
            checks++;
            if (obs_rdata !== er || obs_err !== ee || obs_lat !== el) begin
                failures++;
                $display("FAIL rand_%0d_resp: w=%b f3=%0d a=%h got rdata=%h err=%b lat=%0d expected %h %b %0d",
                         k, w, f3, a, obs_rdata, obs_err, obs_lat, er, ee, el);
            end
            checks++;
            if (obs_nwr !== ew || obs_ready !== 1'b1 || obs_raddr !== 32'h0) begin
                failures++;
                $display("FAIL rand_%0d_bus: got writes=%0d ready=%b resp_addr=%h expected %0d 1 0",
                         k, obs_nwr, obs_ready, obs_raddr, ew);
            end
            if (ew == 1) begin
                checks++;
                if (obs_waddr !== (a >> 2) || obs_wdata !== ewd) begin
                    failures++;
                    $display("FAIL rand_%0d_wr: got addr=%h data=%h expected %h %h",
                             k, obs_waddr, obs_wdata, a >> 2, ewd);
                end
            end
            checks++;
            if (mem[a[7:2]] !== ref_mem[a[7:2]]) begin
                failures++;
                $display("FAIL rand_%0d_mem: got %h expected %h",
                         k, mem[a[7:2]], ref_mem[a[7:2]]);
            end
        end
    endtask

    task automatic test_back_to_back;
        test_random(40, 1);
    endtask

`ifdef LSU_STATS_EN
    task automatic test_stats;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        run_op(0, 3'd2, 32'h10, 32'h0, 0);
        run_op(0, 3'd4, 32'h21, 32'h0, 0);
        run_op(1, 3'd2, 32'h30, 32'h12345678, 0);
        run_op(0, 3'd2, 32'h31, 32'h0, 0);
        ref_mem[12] = 32'h12345678;
        @(negedge clock);
        checks++;
        if (stat_loads !== 32'd2 || stat_stores !== 32'd1 || stat_faults !== 32'd1) begin
            failures++;
            $display("FAIL stats_count: got %0d/%0d/%0d expected 2/1/1",
                     stat_loads, stat_stores, stat_faults);
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (stat_loads !== 32'd0 || stat_stores !== 32'd0 || stat_faults !== 32'd0) begin
            failures++;
            $display("FAIL stats_reset: got %0d/%0d/%0d expected 0/0/0",
                     stat_loads, stat_stores, stat_faults);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_store_word();
        test_loads();
        test_subword_store();
        test_faults();
        test_reset_abort();
        test_random(150, 0);
        test_back_to_back();
`ifdef LSU_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
